// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
//   Shared processor definitions used by the fetch stage and the later
//   pipeline stages. It holds the datapath widths, the NOP encoding, the HALT
//   opcode, the fetch state encoding, and the jump-offset sign extension.
// -----------------------------------------------------------------------------
package proc_pkg;

    localparam int PC_W   = 8;
    localparam int INST_W = 16;

    localparam logic [3:0]        HALT_OPC = 4'hF;
    localparam logic [INST_W-1:0] NOP      = 16'h0000;

    // The encoding is fixed explicitly so that it matches older tooling and
    // waveform decoders.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } fetch_state_e;

    // Sign-extends the 3-bit two's-complement jump offset to the PC width.
    function automatic logic [PC_W-1:0] sext_jmp(input logic signed [2:0] off);
        return {{(PC_W-3){off[2]}}, off};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
//   Groups the fetch-stage signals: the decode control inputs, the
//   instruction-memory read port, the IF/ID outputs and the status outputs.
//   master : the fetch stage itself.
//   slave  : the environment (decode stage + instruction memory).
//   Signals:
//     stall, jmp, jmp_val  decode -> fetch control
//     imem_addr/imem_data  combinational instruction-memory read
//     pc_out, inst_out,    IF/ID pipeline register contents
//     inst_valid
//     eop, inst_count      end-of-program flag, valid-fetch counter
// -----------------------------------------------------------------------------
interface fetch_stage_if;
    import proc_pkg::*;

    logic                    stall;
    logic                    jmp;
    logic signed [2:0]       jmp_val;
    logic [PC_W-1:0]         imem_addr;
    logic [INST_W-1:0]       imem_data;
    logic [PC_W-1:0]         pc_out;
    logic [INST_W-1:0]       inst_out;
    logic                    inst_valid;
    logic                    eop;
    logic [15:0]             inst_count;

    modport master (
        input  stall, jmp, jmp_val, imem_data,
        output imem_addr, pc_out, inst_out, inst_valid, eop, inst_count
    );

    modport slave (
        output stall, jmp, jmp_val, imem_data,
        input  imem_addr, pc_out, inst_out, inst_valid, eop, inst_count
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
//   A generic stage pipeline register that holds {pc, inst, valid}.
//   flush : load NOP and clear valid; pc keeps its value (it has priority).
//   hold  : keep all contents.
//   else  : load pc_in / inst_in / valid_in.
//   Ports: clk, rst (sync, active-high), hold, flush, pc_in, inst_in,
//          valid_in, pc_out, inst_out, valid_out.
// -----------------------------------------------------------------------------
module if_id_reg
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [INST_W-1:0] inst_in,
    input  logic              valid_in,
    output logic [PC_W-1:0]   pc_out,
    output logic [INST_W-1:0] inst_out,
    output logic              valid_out
);

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;

    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (flush) begin
            // A squashed slot keeps its pc. Later jump targets are computed
            // relative to this pc.
            inst_d  = NOP;
            valid_d = 1'b0;
        end else if (!hold) begin
            pc_d    = pc_in;
            inst_d  = inst_in;
            valid_d = valid_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            inst_q  <= NOP;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    assign pc_out    = pc_q;
    assign inst_out  = inst_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage. It owns the PC, drives the instruction-memory
//   address, and fills the IF/ID register. It also handles decode stall and
//   jump redirects. When it detects HALT, it drains the pipeline for
//   DRAIN_CYCLES and then raises a sticky eop.
//   Ports:
//     clk  clock
//     rst  synchronous active-high reset
//     bus  fetch_stage_if.master (control in, imem port, IF/ID and status out)
//   Parameter:
//     DRAIN_CYCLES  cycles after HALT leaves IF/ID before eop (must be >= 1)
// -----------------------------------------------------------------------------
module fetch_stage
    import proc_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    fetch_state_e        state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic [15:0]         count_q, count_d;
    logic                eop_q, eop_d;

    logic                ifid_hold;
    logic                ifid_flush;
    logic [PC_W-1:0]     ifid_pc;
    logic [INST_W-1:0]   ifid_inst;
    logic                ifid_valid;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drain_d    = drain_q;
        count_d    = count_q;
        eop_d      = eop_q;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (bus.jmp) begin
                    // The jump is relative to the instruction now in IF/ID.
                    // The word being fetched is squashed, even when it is a
                    // HALT or when a stall is also requested.
                    pc_d       = ifid_pc + sext_jmp(bus.jmp_val);
                    ifid_flush = 1'b1;
                end else if (bus.stall) begin
                    ifid_hold = 1'b1;
                end else begin
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                    if (bus.imem_data[INST_W-1 -: 4] == HALT_OPC) begin
                        // The PC stays parked on the HALT address.
                        drain_d = DRAIN_W'(DRAIN_CYCLES);
                        state_d = ST_DRAIN;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end

            ST_DRAIN: begin
                if (bus.stall) begin
                    ifid_hold = 1'b1;
                end else begin
                    ifid_flush = 1'b1;
                    drain_d    = drain_q - DRAIN_W'(1);
                    if (drain_q == DRAIN_W'(1)) begin
                        state_d = ST_DONE;
                        eop_d   = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                // The flush path never looks at imem_data, so unknown memory
                // contents cannot reach the outputs after the end of program.
                ifid_flush = 1'b1;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            drain_q <= '0;
            count_q <= '0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drain_q <= drain_d;
            count_q <= count_d;
            eop_q   <= eop_d;
        end
    end

    if_id_reg u_if_id (
        .clk       (clk),
        .rst       (rst),
        .hold      (ifid_hold),
        .flush     (ifid_flush),
        .pc_in     (pc_q),
        .inst_in   (bus.imem_data),
        .valid_in  (1'b1),
        .pc_out    (ifid_pc),
        .inst_out  (ifid_inst),
        .valid_out (ifid_valid)
    );

    assign bus.imem_addr  = pc_q;
    assign bus.pc_out     = ifid_pc;
    assign bus.inst_out   = ifid_inst;
    assign bus.inst_valid = ifid_valid;
    assign bus.eop        = eop_q;
    assign bus.inst_count = count_q;

endmodule
